fight_match_ctrl: RTL and testbench

- Parametrised successor of the two-player fighting-game top: adds configurable health width and max, best-of-N round scoring, an attack cooldown, and a round/match state machine.
- Takes per-player action codes qualified by a synchronous `actionEnable` strobe.
- Resolves hits, tracks health per round and declares round and match winners.
- Sits between the player input decoders and the display/score logic.

---
 rtl/fight_pkg.sv | 20 ++
 rtl/fight_player_unit.sv | 83 ++++++++
 rtl/fight_match_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_fight_match_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fight_pkg.sv
// Shared definitions for the fighting-game match controller:
// action codes, match FSM states and per-hit damage amounts.
package fight_pkg;

    localparam logic [2:0] ACT_IDLE   = 3'd0;
    localparam logic [2:0] ACT_ATTACK = 3'd1;
    localparam logic [2:0] ACT_BLOCK  = 3'd2;

    typedef enum logic [1:0] {
        ROUND_PLAY = 2'd0,
        ROUND_END  = 2'd1,
        MATCH_OVER = 2'd2
    } fsm_e;

    localparam int          DMG_W      = 2;
    localparam logic [1:0]  DMG_NONE   = 2'd0;
    localparam logic [1:0]  DMG_HIT    = 2'd1;
    localparam logic [1:0]  DMG_PUNISH = 2'd2;

endpackage

// File: rtl/fight_player_unit.sv
// One player's datapath: health register, attack cooldown down-counter,
// last-accepted-action register and the attack/block accept logic.
// health_nxt exposes the post-hit health so the match FSM can detect a KO
// on the same edge that the hit lands.
module fight_player_unit
    import fight_pkg::*;
#(
    parameter int HEALTH_W   = 3,
    parameter int MAX_HEALTH = 5,
    parameter int COOLDOWN   = 3
) (
    input  logic                clk,
    input  logic                resetGame,
    input  logic                accept_en,
    input  logic [2:0]          action,
    input  logic [DMG_W-1:0]    dmg,
    input  logic                restore,
    input  logic                clear_cd,
    output logic [HEALTH_W-1:0] health,
    output logic [HEALTH_W-1:0] health_nxt,
    output logic [2:0]          state,
    output logic                att_ok,
    output logic                blk_ok,
    output logic                cd_busy
);

    localparam int CW = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);

    logic [CW-1:0]     cd;
    logic [2:0]        acc_code;
    logic [HEALTH_W:0] h_ext;
    logic [HEALTH_W:0] d_ext;

    // Accept logic: gated attacks and unknown codes collapse to IDLE; health saturates at 0.
    always_comb begin
        cd_busy  = (cd != '0);
        acc_code = ACT_IDLE;
        if (action == ACT_ATTACK && !cd_busy) begin
            acc_code = ACT_ATTACK;
        end else if (action == ACT_BLOCK) begin
            acc_code = ACT_BLOCK;
        end
        att_ok = accept_en && (acc_code == ACT_ATTACK);
        blk_ok = accept_en && (acc_code == ACT_BLOCK);

        h_ext      = {1'b0, health};
        d_ext      = (HEALTH_W + 1)'(dmg);
        health_nxt = health;
        if (restore) begin
            health_nxt = HEALTH_W'(MAX_HEALTH);
        end else if (accept_en) begin
            if (h_ext <= d_ext) begin
                health_nxt = '0;
            end else begin
                health_nxt = HEALTH_W'(h_ext - d_ext);
            end
        end
    end

    // Health, action record and cooldown registers.
    always_ff @(posedge clk or negedge resetGame) begin
        if (!resetGame) begin
            health <= HEALTH_W'(MAX_HEALTH);
            state  <= ACT_IDLE;
            cd     <= '0;
        end else begin
            health <= health_nxt;
            if (restore) begin
                state <= ACT_IDLE;
            end else if (accept_en) begin
                state <= acc_code;
            end
            if (clear_cd) begin
                cd <= '0;
            end else if (att_ok) begin
                cd <= CW'(COOLDOWN);
            end else if (cd != '0) begin
                cd <= cd - CW'(1);
            end
        end
    end

endmodule

// File: rtl/fight_match_ctrl.sv
// Two-player match controller: resolves hits between two player units,
// tracks round wins and declares the match winner.
// Optional build macro FIGHT_PUNISH_EN: a hit landing on a player whose
// cooldown is still running does double damage.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ROUND_PLAY | strobed actions accepted, hits resolved, KO detected
// ROUND_END  | roundOver=1, actions ignored, intermission counting down
// MATCH_OVER | isGameOver=1, winner flag set, all outputs frozen
module fight_match_ctrl
    import fight_pkg::*;
#(
    parameter int HEALTH_W      = 3,
    parameter int MAX_HEALTH    = 5,
    parameter int ROUNDS_TO_WIN = 2,
    parameter int COOLDOWN      = 3,
    parameter int INTERMISSION  = 4
) (
    input  logic                                 clk,
    input  logic                                 resetGame,
    input  logic                                 actionEnable,
    input  logic [2:0]                           action1,
    input  logic [2:0]                           action2,
    output logic [HEALTH_W-1:0]                  health1,
    output logic [HEALTH_W-1:0]                  health2,
    output logic [2:0]                           state1,
    output logic [2:0]                           state2,
    output logic [$clog2(ROUNDS_TO_WIN+1)-1:0]   rounds1,
    output logic [$clog2(ROUNDS_TO_WIN+1)-1:0]   rounds2,
    output logic                                 roundOver,
    output logic                                 firstWin,
    output logic                                 secondWin,
    output logic                                 isGameOver
);

    localparam int RW       = $clog2(ROUNDS_TO_WIN + 1);
    localparam int INTER_LD = (INTERMISSION < 1) ? 1 : INTERMISSION;
    localparam int IW       = $clog2(INTER_LD + 1);

    fsm_e                fsm;
    logic [IW-1:0]       inter;
    logic                accept_en;
    logic                restore;
    logic                clear_cd;
    logic [DMG_W-1:0]    dmg1;
    logic [DMG_W-1:0]    dmg2;
    logic [HEALTH_W-1:0] health1_nxt;
    logic [HEALTH_W-1:0] health2_nxt;
    logic                att1, att2, blk1, blk2;
    logic                cd_busy1, cd_busy2;
    logic                ko1, ko2;
    logic [RW-1:0]       r1_inc, r2_inc;

    // Hit resolution and per-edge control strobes for the player units.
    always_comb begin
        accept_en = actionEnable && (fsm == ROUND_PLAY);
        restore   = (fsm == ROUND_END) && (inter == IW'(1));
        clear_cd  = (fsm != ROUND_PLAY);

        dmg1 = DMG_NONE;
        dmg2 = DMG_NONE;
`ifdef FIGHT_PUNISH_EN
        if (att2 && !blk1) dmg1 = cd_busy1 ? DMG_PUNISH : DMG_HIT;
        if (att1 && !blk2) dmg2 = cd_busy2 ? DMG_PUNISH : DMG_HIT;
`else
        if (att2 && !blk1) dmg1 = DMG_HIT;
        if (att1 && !blk2) dmg2 = DMG_HIT;
`endif

        ko1    = (health1_nxt == '0);
        ko2    = (health2_nxt == '0);
        r1_inc = rounds1 + RW'(1);
        r2_inc = rounds2 + RW'(1);
    end

    fight_player_unit #(
        .HEALTH_W   (HEALTH_W),
        .MAX_HEALTH (MAX_HEALTH),
        .COOLDOWN   (COOLDOWN)
    ) u_p1 (
        .clk        (clk),
        .resetGame  (resetGame),
        .accept_en  (accept_en),
        .action     (action1),
        .dmg        (dmg1),
        .restore    (restore),
        .clear_cd   (clear_cd),
        .health     (health1),
        .health_nxt (health1_nxt),
        .state      (state1),
        .att_ok     (att1),
        .blk_ok     (blk1),
        .cd_busy    (cd_busy1)
    );

    fight_player_unit #(
        .HEALTH_W   (HEALTH_W),
        .MAX_HEALTH (MAX_HEALTH),
        .COOLDOWN   (COOLDOWN)
    ) u_p2 (
        .clk        (clk),
        .resetGame  (resetGame),
        .accept_en  (accept_en),
        .action     (action2),
        .dmg        (dmg2),
        .restore    (restore),
        .clear_cd   (clear_cd),
        .health     (health2),
        .health_nxt (health2_nxt),
        .state      (state2),
        .att_ok     (att2),
        .blk_ok     (blk2),
        .cd_busy    (cd_busy2)
    );

    // Round/match FSM with intermission down-counter, scores and win flags.
    always_ff @(posedge clk or negedge resetGame) begin
        if (!resetGame) begin
            fsm        <= ROUND_PLAY;
            inter      <= '0;
            rounds1    <= '0;
            rounds2    <= '0;
            roundOver  <= 1'b0;
            firstWin   <= 1'b0;
            secondWin  <= 1'b0;
            isGameOver <= 1'b0;
        end else begin
            case (fsm)
                ROUND_PLAY: begin
                    if (accept_en) begin
                        if (ko1 && ko2) begin
                            fsm       <= ROUND_END;
                            roundOver <= 1'b1;
                            inter     <= IW'(INTER_LD);
                        end else if (ko2) begin
                            rounds1 <= r1_inc;
                            if (r1_inc == RW'(ROUNDS_TO_WIN)) begin
                                fsm        <= MATCH_OVER;
                                firstWin   <= 1'b1;
                                isGameOver <= 1'b1;
                            end else begin
                                fsm       <= ROUND_END;
                                roundOver <= 1'b1;
                                inter     <= IW'(INTER_LD);
                            end
                        end else if (ko1) begin
                            rounds2 <= r2_inc;
                            if (r2_inc == RW'(ROUNDS_TO_WIN)) begin
                                fsm        <= MATCH_OVER;
                                secondWin  <= 1'b1;
                                isGameOver <= 1'b1;
                            end else begin
                                fsm       <= ROUND_END;
                                roundOver <= 1'b1;
                                inter     <= IW'(INTER_LD);
                            end
                        end
                    end
                end
                ROUND_END: begin
                    if (inter == IW'(1)) begin
                        fsm       <= ROUND_PLAY;
                        roundOver <= 1'b0;
                        inter     <= '0;
                    end else begin
                        inter <= inter - IW'(1);
                    end
                end
                MATCH_OVER: begin
                    fsm <= MATCH_OVER;
                end
                default: begin
                    fsm <= ROUND_PLAY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fight_match_ctrl.sv
// Directed bench for fight_match_ctrl at default parameters
// (HEALTH_W=3, MAX_HEALTH=5, ROUNDS_TO_WIN=2, COOLDOWN=3, INTERMISSION=4).
module tb_fight_match_ctrl;

    localparam logic [2:0] IDL = 3'd0;
    localparam logic [2:0] ATK = 3'd1;
    localparam logic [2:0] BLK = 3'd2;

    logic       clk = 1'b0;
    logic       resetGame = 1'b0;
    logic       actionEnable = 1'b0;
    logic [2:0] action1 = 3'd0;
    logic [2:0] action2 = 3'd0;
    logic [2:0] health1, health2;
    logic [2:0] state1, state2;
    logic [1:0] rounds1, rounds2;
    logic       roundOver, firstWin, secondWin, isGameOver;

    int checks   = 0;
    int failures = 0;
    int n;

    fight_match_ctrl dut (
        .clk          (clk),
        .resetGame    (resetGame),
        .actionEnable (actionEnable),
        .action1      (action1),
        .action2      (action2),
        .health1      (health1),
        .health2      (health2),
        .state1       (state1),
        .state2       (state2),
        .rounds1      (rounds1),
        .rounds2      (rounds2),
        .roundOver    (roundOver),
        .firstWin     (firstWin),
        .secondWin    (secondWin),
        .isGameOver   (isGameOver)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; drives one strobe across the next posedge.
    task automatic strobe(input logic [2:0] a1, input logic [2:0] a2);
        actionEnable = 1'b1;
        action1 = a1;
        action2 = a2;
        @(negedge clk);
        actionEnable = 1'b0;
        action1 = IDL;
        action2 = IDL;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic do_reset();
        resetGame = 1'b0;
        idle(2);
        resetGame = 1'b1;
    endtask

    // Counts negedges with roundOver high; bounded.
    task automatic wait_round_end(output int cnt);
        cnt = 0;
        while (roundOver && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        do_reset();

        // Reset values
        check("rst_health1", health1, 5);
        check("rst_health2", health2, 5);
        check("rst_state1", state1, 0);
        check("rst_rounds1", rounds1, 0);
        check("rst_flags", {roundOver, firstWin, secondWin, isGameOver}, 0);

        // P1 knocks out P2 with 5 spaced attacks
        for (int i = 0; i < 5; i++) begin
            strobe(ATK, IDL);
            check("ko_health2", health2, 4 - i);
            if (i == 0) begin
                check("ko_state1", state1, 1);
                check("ko_state2", state2, 0);
            end
            if (i < 4) idle(3);
        end
        check("ko_rounds1", rounds1, 1);
        check("ko_roundOver", roundOver, 1);
        check("ko_not_over", isGameOver, 0);
        wait_round_end(n);
        check("inter_len", n, 4);
        check("restore_h1", health1, 5);
        check("restore_h2", health2, 5);
        check("restore_st1", state1, 0);

        // Attack against block
        strobe(ATK, BLK);
        check("blk_health2", health2, 5);
        check("blk_state1", state1, 1);
        check("blk_state2", state2, 2);

        // Cooldown: back-to-back attacks, only first lands
        idle(4);
        strobe(ATK, IDL);
        check("cd_first_h2", health2, 4);
        strobe(ATK, IDL);
        check("cd_second_h2", health2, 4);
        check("cd_second_st1", state1, 0);

        // Double KO draw
        do_reset();
        for (int i = 0; i < 5; i++) begin
            strobe(ATK, ATK);
            if (i < 4) idle(3);
        end
        check("draw_h1", health1, 0);
        check("draw_h2", health2, 0);
        check("draw_rounds", {rounds1, rounds2}, 0);
        check("draw_roundOver", roundOver, 1);
        wait_round_end(n);
        check("draw_inter", n, 4);

        // P2 wins two rounds
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 5; i++) begin
                strobe(IDL, ATK);
                if (i < 4) idle(3);
            end
            check("p2_rounds2", rounds2, r + 1);
            if (r == 0) begin
                check("p2_r1_roundOver", roundOver, 1);
                wait_round_end(n);
                check("p2_r1_inter", n, 4);
            end
        end
        check("p2_secondWin", secondWin, 1);
        check("p2_firstWin", firstWin, 0);
        check("p2_gameOver", isGameOver, 1);
        check("p2_roundOver", roundOver, 0);
        check("p2_h1", health1, 0);

        // Frozen in MATCH_OVER
        for (int i = 0; i < 2; i++) begin
            strobe(ATK, ATK);
            idle(3);
        end
        check("frz_h1", health1, 0);
        check("frz_h2", health2, 5);
        check("frz_st1", state1, 0);
        check("frz_st2", state2, 1);
        check("frz_rounds2", rounds2, 2);
        check("frz_gameOver", isGameOver, 1);

        // Async reset mid-cycle
        #2 resetGame = 1'b0;
        #1;
        check("arst_h1", health1, 5);
        check("arst_st2", state2, 0);
        check("arst_rounds2", rounds2, 0);
        check("arst_flags", {roundOver, firstWin, secondWin, isGameOver}, 0);
        @(negedge clk);
        resetGame = 1'b1;

        // Hit on a player still in cooldown
        strobe(IDL, ATK);
        check("pun_h1", health1, 4);
        strobe(ATK, IDL);
`ifdef FIGHT_PUNISH_EN
        check("pun_h2", health2, 3);
`else
        check("pun_h2", health2, 4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
